// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: width defaults and the
// fetch FSM state type.
package instr_fetch_unit_pkg;

  // Datapath widths shared with the rest of the core (`RegWidth / `InstrWidth).
  localparam int REG_WIDTH           = 16;
  localparam int INSTR_WIDTH_DEFAULT = 16;

  // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response
  // belongs to a flushed stream and will be discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush. The head is presented from
// registered storage and reads as zero while the buffer is empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push_i && !flush_i && !full;
  assign do_pop  = pop_i && !flush_i && !empty;

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage written on push.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; the occupancy count alone
    // decides which entries are meaningful, so it can map to plain RAM.
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: word-addressed PC generation, single-outstanding memory
// request FSM, and a prefetch FIFO feeding decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = REG_WIDTH,
  parameter int                    INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   instr_ready
);

  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int              EW        = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [CW:0]     DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           committed;
  logic [EW-1:0]         fifo_head;
  logic                  grant, push, pop;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: track whether the single outstanding response is kept or dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (grant) state_d = WAIT;
      WAIT: begin
        if (redirect_valid)  state_d = mem_rvalid ? IDLE : DROP;
        else if (mem_rvalid) state_d = grant ? WAIT : IDLE;
      end
      DROP: if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: issue only when a FIFO slot is reserved for every response in flight.
  always_comb begin
    committed = {1'b0, fifo_count} + {{CW{1'b0}}, (state_q == WAIT)};
    mem_req   = !RST && !halt && !redirect_valid &&
                (state_q == IDLE || (state_q == WAIT && mem_rvalid)) &&
                (committed < DEPTH_LIM);
    mem_addr  = fetch_pc_q;
    grant     = mem_req && mem_gnt;
    push      = (state_q == WAIT) && mem_rvalid && !redirect_valid;
    pop       = instr_valid && instr_ready;
  end

  // Next fetch PC and the PC of the request currently in flight.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_pc_d   = out_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (grant) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      out_pc_d   = fetch_pc_q;
    end
  end

  // PC registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
      out_pc_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_pc_q   <= out_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  ({out_pc_q, mem_rdata}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .valid_o (instr_valid),
    .count_o (fifo_count)
  );

  assign {instr_pc, instr} = fifo_head;

  // Memory must only answer a request that is actually outstanding.
  a_no_rvalid_in_idle: assert property (@(posedge CLK) disable iff (RST)
    !(state_q == IDLE && mem_rvalid));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table-driven startup/backpressure vectors,
// directed redirect/halt/reset-PC sequences, and a randomized run against a
// queue-based reference model of the delivered instruction stream.
module tb_instr_fetch_unit;

  localparam int          DEPTH     = 4;
  localparam logic [15:0] KEY       = 16'hA5A5;
  localparam logic [15:0] RESET_PC2 = 16'hFFFE;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DUT 1 (RESET_PC = 0)
  logic        RST, halt, redirect_valid, instr_ready;
  logic [15:0] redirect_pc;
  logic        mem_req, mem_gnt, mem_rvalid, instr_valid;
  logic [15:0] mem_addr, mem_rdata, instr, instr_pc;

  // DUT 2 (RESET_PC = FFFE), free-running
  logic        rst2, mem_req2, mem_gnt2, mem_rvalid2, instr_valid2;
  logic [15:0] mem_addr2, mem_rdata2, instr2, instr_pc2;

  instr_fetch_unit u_dut (
    .CLK(CLK), .RST(RST), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  instr_fetch_unit #(.RESET_PC(RESET_PC2)) u_dut2 (
    .CLK(CLK), .RST(rst2), .halt(1'b0), .redirect_valid(1'b0),
    .redirect_pc(16'h0000), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_gnt(mem_gnt2), .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_ready(1'b1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [15:0] pc; logic [15:0] data; } entry_t;
  typedef enum { OUT_NONE, OUT_KEPT, OUT_DROPPED } outst_e;

  entry_t      exp_q[$];
  outst_e      outst    = OUT_NONE;
  logic [15:0] exp_pc   = '0;
  logic [15:0] outst_pc = '0;
  bit          model_ok = 0;
  int          delivered = 0;

  // memory models
  bit          m_pend = 0;  logic [15:0] m_addr = '0; int m_cnt = 0;
  int          fixed_lat = 1;
  bit          rand_lat = 0, rand_gnt = 0;
  bit          m2_pend = 0; logic [15:0] m2_addr = '0;

  // values sampled before the edge
  bit          s_exp_req, s_gnt, s_rvalid, s_pop, s_req, s2_req;
  logic [15:0] s_addr, s2_addr;

  task automatic drive_and_settle();
    bit exp_req;
    mem_rvalid  = !RST && m_pend && (m_cnt == 1);
    mem_rdata   = mem_rvalid ? (m_addr ^ KEY) : 16'($urandom);
    mem_gnt     = rand_gnt ? ($urandom_range(0, 9) < 7) : 1'b1;
    mem_rvalid2 = !rst2 && m2_pend;
    mem_rdata2  = mem_rvalid2 ? (m2_addr ^ KEY) : 16'($urandom);
    mem_gnt2    = 1'b1;
    #1;
    exp_req = !RST && !halt && !redirect_valid &&
              (outst == OUT_NONE || (outst == OUT_KEPT && mem_rvalid)) &&
              (exp_q.size() + ((outst == OUT_KEPT) ? 1 : 0) < DEPTH);
    if (model_ok) begin
      check("mdl_mem_req", mem_req, exp_req);
      if (exp_req) check("mdl_mem_addr", mem_addr, exp_pc);
      check("mdl_instr_valid", instr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("mdl_instr_pc", instr_pc, exp_q[0].pc);
        check("mdl_instr", instr, exp_q[0].data);
      end
    end
    s_exp_req = exp_req;
    s_req     = (mem_req === 1'b1);
    s_addr    = mem_addr;
    s_gnt     = mem_gnt;
    s_rvalid  = mem_rvalid;
    s_pop     = (exp_q.size() != 0) && instr_ready;
    s2_req    = (mem_req2 === 1'b1);
    s2_addr   = mem_addr2;
  endtask

  task automatic clock_and_update();
    @(posedge CLK);
    if (RST) begin
      exp_q.delete();
      exp_pc   = 16'h0000;
      outst    = OUT_NONE;
      m_pend   = 0;
      model_ok = 1;
    end else begin
      if (redirect_valid) begin
        exp_q.delete();
        exp_pc = redirect_pc;
        if (s_rvalid)               outst = OUT_NONE;
        else if (outst == OUT_KEPT) outst = OUT_DROPPED;
      end else begin
        if (s_pop) begin
          void'(exp_q.pop_front());
          delivered++;
        end
        if (s_rvalid) begin
          if (outst == OUT_KEPT) exp_q.push_back(entry_t'{outst_pc, outst_pc ^ KEY});
          outst = OUT_NONE;
        end
        if (s_exp_req && s_gnt) begin
          outst    = OUT_KEPT;
          outst_pc = exp_pc;
          exp_pc   = exp_pc + 16'd1;
        end
      end
      if (s_rvalid)    m_pend = 0;
      else if (m_pend) m_cnt--;
      if (s_req && s_gnt) begin
        m_pend = 1;
        m_addr = s_addr;
        m_cnt  = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
      end
    end
    if (rst2) m2_pend = 0;
    else begin
      m2_pend = s2_req;
      m2_addr = s2_addr;
    end
    #1;
  endtask

  task automatic step();
    drive_and_settle();
    clock_and_update();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          ready;
    bit          req;
    logic [15:0] addr;
    bit          valid;
    logic [15:0] pc;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit rst, bit ready, bit req, logic [15:0] addr,
                              bit valid, logic [15:0] pc);
    vec_t v;
    v.rst = rst; v.ready = ready; v.req = req; v.addr = addr; v.valid = valid; v.pc = pc;
    vt.push_back(v);
  endfunction

  initial begin
    bit          found, seen;
    logic [15:0] p;

    // Startup stream with ready=1: pc 0,1,2,... two cycles after release.
    add(0, 1, 1, 16'd0, 0, 16'd0);
    add(0, 1, 1, 16'd1, 0, 16'd0);
    add(0, 1, 1, 16'd2, 1, 16'd0);
    add(0, 1, 1, 16'd3, 1, 16'd1);
    add(0, 1, 1, 16'd4, 1, 16'd2);
    add(0, 1, 1, 16'd5, 1, 16'd3);
    // Reset cycle: no request while RST is high.
    add(1, 0, 0, 16'd0, 1, 16'd4);
    // ready=0 for 10 cycles: four requests then stop, head stays at pc 0.
    add(0, 0, 1, 16'd0, 0, 16'd0);
    add(0, 0, 1, 16'd1, 0, 16'd0);
    add(0, 0, 1, 16'd2, 1, 16'd0);
    add(0, 0, 1, 16'd3, 1, 16'd0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 16'd0, 1, 16'd0);
    // ready rises: drain in order and resume fetching at pc 4.
    add(0, 1, 0, 16'd0, 1, 16'd0);
    add(0, 1, 1, 16'd4, 1, 16'd1);
    add(0, 1, 1, 16'd5, 1, 16'd2);
    add(0, 1, 1, 16'd6, 1, 16'd3);
    add(0, 1, 1, 16'd7, 1, 16'd4);

    RST = 1; rst2 = 1; halt = 0; redirect_valid = 0; redirect_pc = '0; instr_ready = 1;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    mem_gnt2 = 0; mem_rvalid2 = 0; mem_rdata2 = '0;
    #1;
    step();
    step();
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    RST = 0; rst2 = 0;

    // ---- table-driven vectors ----
    foreach (vt[i]) begin
      RST = vt[i].rst;
      instr_ready = vt[i].ready;
      drive_and_settle();
      check($sformatf("tbl%0d_req", i), mem_req, vt[i].req);
      if (vt[i].req) check($sformatf("tbl%0d_addr", i), mem_addr, vt[i].addr);
      check($sformatf("tbl%0d_valid", i), instr_valid, vt[i].valid);
      if (vt[i].valid) begin
        check($sformatf("tbl%0d_pc", i), instr_pc, vt[i].pc);
        check($sformatf("tbl%0d_instr", i), instr, vt[i].pc ^ KEY);
      end
      clock_and_update();
    end
    RST = 0;

    // ---- redirect while WAIT, response arrives 3 cycles later ----
    RST = 1; step(); RST = 0;
    instr_ready = 1; fixed_lat = 3;
    step();                                   // request pc 0 granted
    fixed_lat = 1;
    redirect_valid = 1; redirect_pc = 16'h0040;
    step();
    redirect_valid = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (instr_valid) begin
        check("d1_first_pc", instr_pc, 16'h0040);
        found = 1;
        break;
      end
    end
    if (!found) check("d1_timeout", 0, 1);

    // ---- redirect with same-cycle rvalid and pop ----
    RST = 1; step(); RST = 0;
    repeat (4) step();
    redirect_valid = 1; redirect_pc = 16'h0123;
    drive_and_settle();
    check("d2_valid_before", instr_valid, 1);
    clock_and_update();
    redirect_valid = 0;
    check("d2_flushed", instr_valid, 0);
    drive_and_settle();
    check("d2_req", mem_req, 1);
    check("d2_addr", mem_addr, 16'h0123);
    clock_and_update();
    repeat (3) step();

    // ---- halt while WAIT ----
    RST = 1; step(); RST = 0;
    fixed_lat = 2;
    step();                                   // request pc 0 granted
    halt = 1;
    seen = 0;
    repeat (5) begin
      drive_and_settle();
      check("d3_no_req", mem_req, 0);
      clock_and_update();
      if (instr_valid && instr_pc == 16'h0000) seen = 1;
    end
    check("d3_delivered", seen, 1);
    halt = 0;
    drive_and_settle();
    check("d3_resume_req", mem_req, 1);
    check("d3_resume_addr", mem_addr, 16'h0001);
    clock_and_update();
    fixed_lat = 1;

    // ---- randomized run against the model ----
    rand_gnt = 1; rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      RST            = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = 16'($urandom);
      instr_ready    = ($urandom_range(0, 9) < 6);
      step();
    end
    check("rand_progress", delivered > 300, 1);
    RST = 1; halt = 0; redirect_valid = 0; rand_gnt = 0; rand_lat = 0;
    step();
    RST = 0;

    // ---- RESET_PC = FFFE wrap and mid-stream reset ----
    rst2 = 1; step(); rst2 = 0;
    step(); step();
    p = RESET_PC2;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d4_valid%0d", k), instr_valid2, 1);
      check($sformatf("d4_pc%0d", k), instr_pc2, p);
      check($sformatf("d4_instr%0d", k), instr2, p ^ KEY);
      p = p + 16'd1;
      step();
    end
    rst2 = 1; step(); rst2 = 0;
    check("d4_rst_valid", instr_valid2, 0);
    check("d4_rst_instr", instr2, 0);
    check("d4_rst_pc", instr_pc2, 0);
    drive_and_settle();
    check("d4_refetch_req", mem_req2, 1);
    check("d4_refetch_addr", mem_addr2, RESET_PC2);
    clock_and_update();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage, directly upstream of the decode/control stage.
- Generates the word-addressed PC and issues read requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned {pc, instr} pairs in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Supports halt (stop fetching) and redirect (branch/jump: flush and restart at a new PC).

Parameters:
- ADDR_WIDTH, 16, PC / instruction-memory word-address width (matches `RegWidth).
- INSTR_WIDTH, 16, instruction width (matches `InstrWidth).
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, >= 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- halt  in  1  decode has halted; blocks new memory requests.
- redirect_valid  in  1  flush buffer and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  new fetch address.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  INSTR_WIDTH  read data.
- instr_valid  out  1  FIFO head valid.
- instr  out  INSTR_WIDTH  FIFO head instruction.
- instr_pc  out  ADDR_WIDTH  PC of FIFO head.
- instr_ready  in  1  decode consumes head when instr_valid and instr_ready are both high.

Behaviour:
- Reset (RST high at an edge):
  - fetch_pc = RESET_PC; FIFO empty (count = 0); state IDLE.
  - instr_valid = 0, instr = 0, instr_pc = 0; mem_req = 0 during any cycle in which RST is high.
- State machine:
  - IDLE: no request outstanding.
  - WAIT: one request granted, response will be kept.
  - DROP: one request granted, response will be discarded.
  - At most one request is outstanding at any time.
- Issue condition (combinational, uses registered count): !RST && !halt && !redirect_valid && (state == IDLE || (state == WAIT && mem_rvalid)) && count + (state == WAIT ? 1 : 0) < FIFO_DEPTH.
  - mem_req = issue condition; mem_addr = fetch_pc.
  - mem_req is recomputed every cycle and may drop before a grant. The memory must not rely on request stability.
- Handshake is mem_req && mem_gnt:
  - fetch_pc <= fetch_pc + 1, wrapping modulo 2^ADDR_WIDTH.
  - Next state is WAIT.
- WAIT with mem_rvalid:
  - Push {pc_of_outstanding, mem_rdata}; the outstanding PC is captured at grant.
  - Next state is IDLE unless a new grant occurs in the same cycle, in which case it stays WAIT. This gives back-to-back throughput of 1 instr/cycle with 1-cycle memory.
- DROP with mem_rvalid: data discarded; go to IDLE. No issue from DROP in the same cycle.
- Redirect (redirect_valid high):
  - FIFO flushed (count = 0), fetch_pc <= redirect_pc, no issue this cycle.
  - WAIT without rvalid → DROP.
  - WAIT with rvalid or DROP with rvalid → IDLE; data not pushed.
  - DROP without rvalid stays DROP.
  - Redirect overrides a same-cycle push and a same-cycle pop.
- Halt:
  - Blocks new issues only.
  - An outstanding response is still pushed.
  - FIFO keeps draining to decode.
  - Deasserting halt resumes at the current fetch_pc.
- FIFO:
  - Push and pop in the same cycle leave count unchanged.
  - A pop when empty is ignored.
  - A push can never occur when full; the issue rule guarantees a reserved slot.
  - instr/instr_pc are driven from the head, registered storage, with no combinational path from mem_rdata.
- Latency: with a 1-cycle memory, granted at cycle N, rvalid at N+1, instr_valid at N+2.
- RST mid-operation: state returns to the reset state immediately. Any in-flight response arriving later is ignored because state is IDLE.
- Assertion: mem_rvalid while IDLE is a protocol error; it is flagged in simulation and the data is ignored.

Decomposition:
- Shared defs package/header:
  - fetch state enum {IDLE, WAIT, DROP}.
  - Width constants reused from `RegWidth / `InstrWidth.
- One sub-module: fetch_fifo.
  - Parameterised synchronous FIFO: push, pop, flush, data in/out, count.
  - Pointer wrap on FIFO_DEPTH.
- The FSM, PC and issue logic stay in instr_fetch_unit.

Test Plan:
- Reset, 1-cycle memory returning data = addr ^ 16'hA5A5, instr_ready = 1 → instr_pc sequence 0, 1, 2, 3 on consecutive cycles starting 2 cycles after reset release; instr = 16'hA5A5, 16'hA5A4, …
- instr_ready = 0 for 10 cycles → mem_req stops once count + outstanding = 4. Exactly 4 entries are buffered (pc 0–3), then drained in order when ready rises.
- Redirect to 16'h0040 while WAIT with the response arriving 3 cycles later → that response is dropped; the next instr_valid has instr_pc = 16'h0040; no stale pc appears.
- Redirect in the same cycle as mem_rvalid and a pop → FIFO empty next cycle, state IDLE, next request at redirect_pc.
- halt asserted while WAIT → the response is still delivered and there is no new mem_req. halt released → mem_addr continues at the next sequential pc.
- RESET_PC = 16'hFFFE, free-running → instr_pc sequence FFFE, FFFF, 0000, 0001. RST pulsed mid-stream → instr_valid = 0 next cycle and the next fetch is at RESET_PC.
